pulse_scheduler: RTL and testbench

Multi-channel pulse scheduler sharing one single-cycle pulse output between `CHANNELS` requesters. Each channel counts its input high-cycles as pending pulses in a saturating counter. A round-robin arbiter replays the pending pulses one at a time on `pulse_out`, always with one low cycle between pulses, and tags each pulse with its source index. It sits upstream of any consumer that accepts only isolated one-cycle pulses from a single source, such as event counters or interrupt aggregators.

---
 rtl/pulse_scheduler_pkg.sv | 16 +
 rtl/round_robin_arbiter.sv | 36 +++
 rtl/pulse_scheduler.sv | 123 ++++++++++++
 tb/tb_pulse_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_scheduler_pkg.sv
// Shared types and helpers for the pulse scheduler.
//   pulse_scheduler_state_t : IDLE / PULSE / GAP sequencing states
//   channel_index_width()   : width of a channel index, never below 1 bit
package pulse_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } pulse_scheduler_state_t;

    function automatic int channel_index_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter.
//   req_i         : request vector, one bit per requester
//   last_grant_i  : index granted most recently; search starts just above it
//   grant_valid_o : at least one request present
//   grant_idx_o   : first requester found after last_grant_i, wrapping
module round_robin_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic          grant_valid_o,
    output logic [IW-1:0] grant_idx_o
);

    // Two descending passes: the lower bank (indices <= last grant) is the
    // fallback, the upper bank (indices > last grant) overrides it. Scanning
    // downwards leaves the lowest index of the winning bank in place.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i] && (i <= int'(last_grant_i))) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = IW'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i] && (i > int'(last_grant_i))) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Multi-channel pulse scheduler: counts per-channel request cycles and
// replays them one at a time as isolated single-cycle pulses.
//   clock         : rising-edge clock
//   resetn        : asynchronous active-low reset
//   pulse_in      : per-channel request, one pulse per high cycle
//   busy          : per-channel pending counter is saturated
//   pulse_out     : registered single-cycle output pulse
//   pulse_channel : registered source index of the current/last pulse
//
// state | meaning
// IDLE  | nothing pending, waiting for a request
// PULSE | pulse_out high for the granted channel
// GAP   | mandatory low cycle; next grant evaluated here
module pulse_scheduler
    import pulse_scheduler_pkg::*;
#(
    parameter  int CHANNELS            = 3,
    parameter  int PULSE_COUNTER_WIDTH = 3,
    localparam int CHANNEL_INDEX_WIDTH = channel_index_width(CHANNELS)
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [CHANNELS-1:0]            pulse_in,
    output logic [CHANNELS-1:0]            busy,
    output logic                           pulse_out,
    output logic [CHANNEL_INDEX_WIDTH-1:0] pulse_channel
);

    localparam int CIW = CHANNEL_INDEX_WIDTH;
    localparam int W   = PULSE_COUNTER_WIDTH;
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    pulse_scheduler_state_t state_q, state_d;
    logic [W-1:0]           count_q [CHANNELS];
    logic [W-1:0]           count_d [CHANNELS];
    logic [CIW-1:0]         last_grant_q;
    logic                   pulse_out_q;
    logic [CIW-1:0]         pulse_channel_q;

    logic [CHANNELS-1:0]    pending;
    logic [CHANNELS-1:0]    granted;
    logic                   grant_valid;
    logic [CIW-1:0]         grant_idx;
    logic                   grant_en;

    // A fresh request counts as pending in its own cycle so that an idle
    // scheduler can answer with one cycle of latency.
    always_comb begin
        pending = '0;
        busy    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pending[i] = (count_q[i] != '0) | pulse_in[i];
            busy[i]    = (count_q[i] == CNT_MAX);
        end
    end

    round_robin_arbiter #(
        .N  (CHANNELS),
        .IW (CIW)
    ) u_arbiter (
        .req_i         (pending),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                if (grant_valid) begin
                    grant_en = 1'b1;
                    state_d  = PULSE;
                end else begin
                    state_d  = IDLE;
                end
            end
            PULSE:   state_d = GAP;
            default: state_d = IDLE;
        endcase
    end

    // A grant coinciding with a new request leaves the count untouched, so
    // a saturated channel that is being served loses nothing.
    always_comb begin
        granted = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            granted[i] = grant_en && (grant_idx == CIW'(i));
            count_d[i] = count_q[i];
            if (pulse_in[i] && !granted[i]) begin
                if (!busy[i]) begin
                    count_d[i] = count_q[i] + CNT_ONE;
                end
            end else if (granted[i] && !pulse_in[i]) begin
                count_d[i] = count_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            count_q         <= '{default: '0};
            last_grant_q    <= CIW'(CHANNELS - 1);
            pulse_out_q     <= 1'b0;
            pulse_channel_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pulse_out_q <= grant_en;
            if (grant_en) begin
                last_grant_q    <= grant_idx;
                pulse_channel_q <= grant_idx;
            end
        end
    end

    assign pulse_out     = pulse_out_q;
    assign pulse_channel = pulse_channel_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
module tb_pulse_scheduler;
    import pulse_scheduler_pkg::*;

    logic       clock = 1'b0;
    logic       resetn;
    logic [2:0] pulse_in;
    logic [2:0] busy;
    logic       pulse_out;
    logic [1:0] pulse_channel;

    pulse_scheduler #(
        .CHANNELS            (3),
        .PULSE_COUNTER_WIDTH (3)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pulse_in      (pulse_in),
        .busy          (busy),
        .pulse_out     (pulse_out),
        .pulse_channel (pulse_channel)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int exp_q[$];
    int pulse_times[$];
    int pulse_chans[$];
    int seen_cnt[3];
    logic prev_out = 1'b0;

    // Behavioural reference: state 0 idle, 1 pulse, 2 gap.
    int m_cnt[3];
    int m_acc[3];
    int m_state;
    int m_last;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
        end
        m_state = 0;
        m_last  = 2;
    endtask

    task automatic model_step(input logic [2:0] p);
        int pend[3];
        int grant;
        grant = -1;
        for (int i = 0; i < 3; i++) begin
            pend[i] = ((m_cnt[i] != 0) || p[i]) ? 1 : 0;
        end
        if (m_state != 1) begin
            for (int off = 1; off <= 3; off++) begin
                if (grant < 0 && pend[(m_last + off) % 3] != 0) begin
                    grant = (m_last + off) % 3;
                end
            end
        end
        if (m_state == 1)    m_state = 2;
        else if (grant >= 0) m_state = 1;
        else                 m_state = 0;
        for (int i = 0; i < 3; i++) begin
            if (p[i] && i != grant) begin
                if (m_cnt[i] < 7) begin
                    m_cnt[i]++;
                    m_acc[i]++;
                end
            end else if (p[i] && i == grant) begin
                m_acc[i]++;
            end else if (i == grant) begin
                m_cnt[i]--;
            end
        end
        if (grant >= 0) begin
            exp_q.push_back(grant);
            m_last = grant;
        end
    endtask

    task automatic cycle(input logic [2:0] p);
        pulse_in = p;
        model_step(p);
        @(posedge clock);
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy[%0d]", i), int'(busy[i]), (m_cnt[i] == 7) ? 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(3'b000);
    endtask

    task automatic do_reset();
        pulse_in = 3'b000;
        resetn   = 1'b0;
        exp_q.delete();
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        pulse_times.delete();
        pulse_chans.delete();
    endtask

    // Scoreboard monitor: every observed pulse consumes one expected channel.
    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            if (pulse_out) begin
                check("no_back_to_back", int'(prev_out), 0);
                pulse_times.push_back(cyc);
                pulse_chans.push_back(int'(pulse_channel));
                seen_cnt[pulse_channel]++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got channel %0d expected none (cycle %0d)",
                             pulse_channel, cyc);
                end else begin
                    check("pulse_channel", int'(pulse_channel), exp_q.pop_front());
                end
            end
            prev_out = pulse_out;
        end else begin
            prev_out = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int first_busy;
        int exp_chan3[6];
        exp_chan3 = '{0, 1, 2, 0, 1, 2};

        pulse_in = 3'b000;
        resetn   = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_pulse_out", int'(pulse_out), 0);
        check("rst_pulse_channel", int'(pulse_channel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(dut.state_q), int'(IDLE));

        // Single request from IDLE: one pulse, one cycle later, back to IDLE.
        do_reset();
        base = cyc;
        cycle(3'b001);
        idle(1);
        check("t1_state_gap", int'(dut.state_q), int'(GAP));
        idle(1);
        check("t1_state_idle", int'(dut.state_q), int'(IDLE));
        idle(3);
        check("t1_count", pulse_times.size(), 1);
        if (pulse_times.size() == 1) begin
            check("t1_time", pulse_times[0], base + 1);
            check("t1_chan", pulse_chans[0], 0);
        end

        // Channel 1 held for 4 cycles: 4 pulses with period 2.
        do_reset();
        base = cyc;
        for (int k = 0; k < 4; k++) cycle(3'b010);
        idle(8);
        check("t2_count", pulse_times.size(), 4);
        for (int k = 0; k < 4 && k < pulse_times.size(); k++) begin
            check("t2_time", pulse_times[k], base + 1 + 2 * k);
            check("t2_chan", pulse_chans[k], 1);
        end

        // All channels for 2 cycles: order 0,1,2,0,1,2.
        do_reset();
        base = cyc;
        for (int k = 0; k < 2; k++) cycle(3'b111);
        idle(14);
        check("t3_count", pulse_times.size(), 6);
        for (int k = 0; k < 6 && k < pulse_times.size(); k++) begin
            check("t3_time", pulse_times[k], base + 1 + 2 * k);
            check("t3_chan", pulse_chans[k], exp_chan3[k]);
        end

        // Channel 2 held 24 cycles: saturates, 5 requests dropped, 19 pulses.
        do_reset();
        base       = cyc;
        first_busy = -1;
        for (int k = 0; k < 24; k++) begin
            cycle(3'b100);
            if (busy[2] && first_busy < 0) first_busy = cyc;
        end
        check("t4_busy_rise", first_busy, base + 14);
        idle(20);
        check("t4_count", pulse_times.size(), 19);
        check("t4_busy_clear", int'(busy), 0);

        // Reset while channel 0 has 5 pending and a pulse is on the output.
        do_reset();
        for (int k = 0; k < 11; k++) cycle(3'b001);
        check("t5_pulse_before", int'(pulse_out), 1);
        pulse_in = 3'b000;
        #1;
        resetn = 1'b0;
        #1;
        check("t5_pulse_async", int'(pulse_out), 0);
        check("t5_chan_async", int'(pulse_channel), 0);
        check("t5_busy_async", int'(busy), 0);
        exp_q.delete();
        model_reset();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        pulse_times.delete();
        idle(20);
        check("t5_no_pulses", pulse_times.size(), 0);
        check("t5_busy", int'(busy), 0);

        // Random traffic, then drain; per-channel totals must match.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            seen_cnt[i] = 0;
            m_acc[i]    = 0;
        end
        for (int k = 0; k < 200; k++) cycle(3'($urandom_range(0, 7)));
        idle(60);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_total_ch%0d", i), seen_cnt[i], m_acc[i]);
        end
        check("t6_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
